spi_flash_slave: RTL and testbench
==================================

Name: spi_flash_slave

Overview:
- SPI mode-0 flash responder, the target-side counterpart of the team's SPI flash command controller.
- Oversamples the SPI pins with the system clock and decodes the command set WREN/WRDI/RDID/RDSR/READ/PP/SE/BE.
- Maintains the status register bits WIP and WEL.
- Presents a byte-wide memory/erase port to a backing RAM or flash-emulation store.
- Used as a synthesizable flash stand-in for board bring-up and as a bench responder.

Parameters:
- ID_MANUF, 8'hEF: first RDID byte.
- ID_TYPE, 8'h40: second RDID byte.
- ID_CAP, 8'h18: third RDID byte.
- PROG_CYCLES, 16'd64: clk cycles WIP stays high after a PP completes.

Ports:
- clk  in  1  system clock; must be at least 16x the i_spi_dclk frequency.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_spi_cs  in  1  chip select, active-low.
- i_spi_dclk  in  1  SPI clock, mode 0 (idles low).
- i_spi_mosi  in  1  serial data from master, MSB first.
- o_spi_miso  out  1  serial data to master.
- o_mem_addr  out  24  byte address for read, write or sector erase.
- o_mem_rd  out  1  one-cycle read strobe.
- i_mem_rdata  in  8  read data, valid exactly 1 clk after o_mem_rd.
- o_mem_wr  out  1  one-cycle write strobe.
- o_mem_wdata  out  8  write data, qualified by o_mem_wr.
- o_erase_req  out  1  one-cycle erase request.
- o_erase_type  out  1  erase kind: 0 = sector (address on o_mem_addr), 1 = bulk.
- i_erase_done  in  1  one-cycle pulse from the store when the erase finishes.
- o_status  out  8  status register: {6'b0, WEL, WIP}.

Behaviour:
- Reset: all outputs 0, WEL=0, WIP=0, state IDLE, counters 0.
- Input synchronization:
  - cs, dclk and mosi each pass through 2-FF synchronizers.
  - dclk rising and falling edges are detected on the synchronized signal.
  - cs falling edge = transaction start; cs rising edge = transaction end.
- Bit timing:
  - mosi sampled on dclk rise, MSB first; bit counter 0..7.
  - miso updated on dclk fall, driven from the TX shift register.
  - o_spi_miso = 0 whenever cs is high or no response is active.
- States: IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE. cs rise from any state returns to IDLE. Command byte actions:
  - 06 WREN: sets WEL on cs rise, only if exactly 8 bits were clocked.
  - 04 WRDI: clears WEL on cs rise, same 8-bit rule.
  - 9F RDID: returns ID_MANUF, ID_TYPE, ID_CAP, then 00 for every further byte.
  - 05 RDSR: returns o_status repeatedly, resampled at each byte boundary. Accepted while WIP=1.
  - 03 READ: takes 3 address bytes, MSB first.
    - At each byte boundary (address complete, and after each data byte), pulse o_mem_rd with the current address.
    - Load i_mem_rdata into the TX shift register 1 clk later.
    - The address increments after each byte and wraps 24'hFFFFFF -> 0.
  - 02 PP: requires WEL=1, otherwise IGNORE.
    - Takes 3 address bytes, then each complete data byte pulses o_mem_wr with o_mem_wdata and o_mem_addr.
    - Only addr[7:0] increments, so writes wrap within the 256-byte page.
    - On cs rise, if at least 1 byte was written: WEL cleared, WIP=1 for PROG_CYCLES clks, then WIP=0.
  - D8 SE: requires WEL=1 and exactly 32 bits clocked.
    - On cs rise: o_erase_req=1, o_erase_type=0, o_mem_addr = address; WEL cleared, WIP=1.
    - WIP clears on i_erase_done.
  - C7 BE: requires WEL=1 and exactly 8 bits clocked.
    - On cs rise: o_erase_req=1, o_erase_type=1; WEL cleared, WIP=1 until i_erase_done.
  - Any other opcode: IGNORE, miso 0.
- While WIP=1, every opcode except 05 goes to IGNORE.
- Response latency: the MSB of the first response byte is driven at the first dclk fall after the 8th rising edge of the preceding byte.
- cs rises mid-byte:
  - The partial byte is discarded and its PP write is not issued.
  - Bytes already written stand.
  - SE/BE with a bit count other than required are ignored; WEL unchanged.
- i_erase_done while WIP=0 or during a PP timer: ignored.
- Asynchronous reset mid-transaction aborts everything:
  - WIP and WEL cleared.
  - No further strobes.
  - The partial PP/erase is not completed.

Test Plan:
- RDID: cs low, send 9F, clock 4 bytes -> miso returns EF, 40, 18, 00.
- WREN then RDSR: send 06, raise cs; send 05 -> miso returns 02. Send 04 then 05 -> miso returns 00.
- PP without WREN: send 02, 00 10 00, AA -> no o_mem_wr; RDSR returns 00.
- PP with WREN: WREN, then 02, addr 00 01 FE, data 11 22 33 -> three writes at 0001FE/11, 0001FF/22, 000100/33. RDSR returns 01 for PROG_CYCLES clks, then 00.
- READ: store returns addr[7:0]; send 03, addr FF FF FE, clock 3 bytes -> o_mem_rd at FFFFFE, FFFFFF, 000000; miso returns FE, FF, 00.
- SE: WREN, send D8 12 34 56, raise cs -> o_erase_req with type 0, addr 123456. RDSR returns 01 and 03 is ignored until i_erase_done. Separately, raise cs after 20 bits -> no erase request, WEL still 1.

Source files
------------

// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash responder: WREN/WRDI/RDID/RDSR/READ/PP/SE/BE over oversampled SPI pins.
// Latency: pins see 2-FF sync + edge detect (~3 clk); memory strobes 1 clk after the byte-completing edge.
// Backpressure: none; the store must accept a strobe every cycle and return read data 1 clk after o_mem_rd.
//
// Ports:
//   clk, rst_n                          system clock (>=16x dclk), async active-low reset
//   i_spi_cs/i_spi_dclk/i_spi_mosi      SPI pins from the master (cs active-low, dclk idles low)
//   o_spi_miso                          SPI data to the master, forced low while cs is high
//   o_mem_addr/o_mem_rd/i_mem_rdata     byte read port
//   o_mem_wr/o_mem_wdata                byte write port (shares o_mem_addr)
//   o_erase_req/o_erase_type            erase request (0 = sector at o_mem_addr, 1 = bulk)
//   i_erase_done                        erase completion pulse from the store
//   o_status                            status register {6'b0, WEL, WIP}
module spi_flash_slave #(
    parameter logic [7:0]  ID_MANUF    = 8'hEF,
    parameter logic [7:0]  ID_TYPE     = 8'h40,
    parameter logic [7:0]  ID_CAP      = 8'h18,
    parameter logic [15:0] PROG_CYCLES = 16'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_spi_cs,
    input  logic        i_spi_dclk,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic [23:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_mem_wr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_erase_req,
    output logic        o_erase_type,
    input  logic        i_erase_done,
    output logic [7:0]  o_status
);

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_BE   = 8'hC7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA_RD,
        S_DATA_WR,
        S_IGNORE
    } state_t;

    // synchronizers; the third stage is the previous synchronized value for edge detection
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic dclk_s1_q, dclk_s2_q, dclk_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  bits_q, bits_d;          // total rises this transaction, saturating
    logic [1:0]  byte_idx_q, byte_idx_d;  // address byte count / RDID byte index
    logic [7:0]  cmd_q, cmd_d;            // accepted opcode only; 00 when rejected
    logic [6:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        miso_q, miso_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wel_q, wel_d;
    logic        wip_q, wip_d;
    logic [15:0] prog_cnt_q, prog_cnt_d;
    logic        prog_act_q, prog_act_d;
    logic        erase_wait_q, erase_wait_d;
    logic        erase_type_q, erase_type_d;
    logic        wrote_q, wrote_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        erase_req_q, erase_req_d;
    logic        rd_pend_q, rd_pend_d;

    logic       dclk_rise, dclk_fall, cs_fall, cs_rise;
    logic [7:0] rx_byte;
    logic [7:0] status_w;

    assign dclk_rise = dclk_s2_q & ~dclk_s3_q;
    assign dclk_fall = ~dclk_s2_q & dclk_s3_q;
    assign cs_fall   = ~cs_s2_q & cs_s3_q;
    assign cs_rise   = cs_s2_q & ~cs_s3_q;
    assign rx_byte   = {rx_sh_q, mosi_s2_q};
    assign status_w  = {6'b0, wel_q, wip_q};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bits_d       = bits_q;
        byte_idx_d   = byte_idx_q;
        cmd_d        = cmd_q;
        rx_sh_d      = rx_sh_q;
        tx_sh_d      = tx_sh_q;
        miso_d       = miso_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wel_d        = wel_q;
        wip_d        = wip_q;
        prog_cnt_d   = prog_cnt_q;
        prog_act_d   = prog_act_q;
        erase_wait_d = erase_wait_q;
        erase_type_d = erase_type_q;
        wrote_d      = wrote_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        erase_req_d  = 1'b0;
        rd_pend_d    = mem_rd_q;

        // page-program busy timer
        if (prog_act_q) begin
            if (prog_cnt_q <= 16'd1) begin
                wip_d      = 1'b0;
                prog_act_d = 1'b0;
                prog_cnt_d = 16'd0;
            end else begin
                prog_cnt_d = prog_cnt_q - 16'd1;
            end
        end

        // erase completion only counts while an erase is outstanding
        if (erase_wait_q && i_erase_done) begin
            wip_d        = 1'b0;
            erase_wait_d = 1'b0;
        end

        // read data arrives the cycle after the strobe; the address moves on once it is captured
        if (rd_pend_q) begin
            tx_sh_d = i_mem_rdata;
            addr_d  = addr_q + 24'd1;
        end

        // page program only walks the low address byte
        if (mem_wr_q) begin
            addr_d[7:0] = addr_q[7:0] + 8'd1;
        end

        if (cs_fall) begin
            state_d    = S_CMD;
            bit_cnt_d  = 3'd0;
            bits_d     = 6'd0;
            byte_idx_d = 2'd0;
            cmd_d      = 8'h00;
            wrote_d    = 1'b0;
            tx_sh_d    = 8'h00;
            miso_d     = 1'b0;
        end else if (cs_rise) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
            case (cmd_q)
                OP_WREN: if (bits_q == 6'd8) wel_d = 1'b1;
                OP_WRDI: if (bits_q == 6'd8) wel_d = 1'b0;
                OP_PP: begin
                    if (wrote_q) begin
                        wel_d      = 1'b0;
                        wip_d      = 1'b1;
                        prog_cnt_d = PROG_CYCLES;
                        prog_act_d = 1'b1;
                    end
                end
                OP_SE: begin
                    if (bits_q == 6'd32) begin
                        erase_req_d  = 1'b1;
                        erase_type_d = 1'b0;
                        wel_d        = 1'b0;
                        wip_d        = 1'b1;
                        erase_wait_d = 1'b1;
                    end
                end
                OP_BE: begin
                    if (bits_q == 6'd8) begin
                        erase_req_d  = 1'b1;
                        erase_type_d = 1'b1;
                        wel_d        = 1'b0;
                        wip_d        = 1'b1;
                        erase_wait_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (!cs_s2_q && state_q != S_IDLE) begin
            if (dclk_rise) begin
                rx_sh_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bits_q != 6'h3F) bits_d = bits_q + 6'd1;

                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        S_CMD: begin
                            byte_idx_d = 2'd0;
                            if (wip_q && rx_byte != OP_RDSR) begin
                                state_d = S_IGNORE;
                            end else begin
                                case (rx_byte)
                                    OP_WREN, OP_WRDI: begin
                                        cmd_d   = rx_byte;
                                        state_d = S_IGNORE;
                                    end
                                    OP_RDID: begin
                                        cmd_d      = rx_byte;
                                        state_d    = S_DATA_RD;
                                        tx_sh_d    = ID_MANUF;
                                        byte_idx_d = 2'd1;
                                    end
                                    OP_RDSR: begin
                                        cmd_d   = rx_byte;
                                        state_d = S_DATA_RD;
                                        tx_sh_d = status_w;
                                    end
                                    OP_READ: begin
                                        cmd_d   = rx_byte;
                                        state_d = S_ADDR;
                                    end
                                    OP_PP, OP_SE: begin
                                        if (wel_q) begin
                                            cmd_d   = rx_byte;
                                            state_d = S_ADDR;
                                        end else begin
                                            state_d = S_IGNORE;
                                        end
                                    end
                                    OP_BE: begin
                                        // nothing follows the opcode; the erase fires on cs rise
                                        if (wel_q) cmd_d = rx_byte;
                                        state_d = S_IGNORE;
                                    end
                                    default: state_d = S_IGNORE;
                                endcase
                            end
                        end
                        S_ADDR: begin
                            addr_d     = {addr_q[15:0], rx_byte};
                            byte_idx_d = byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd2) begin
                                byte_idx_d = 2'd0;
                                case (cmd_q)
                                    OP_READ: begin
                                        mem_rd_d = 1'b1;
                                        state_d  = S_DATA_RD;
                                    end
                                    OP_PP:   state_d = S_DATA_WR;
                                    // SE: any further bits just push the count past 32
                                    default: state_d = S_IGNORE;
                                endcase
                            end
                        end
                        S_DATA_RD: begin
                            case (cmd_q)
                                OP_RDID: begin
                                    case (byte_idx_q)
                                        2'd1:    tx_sh_d = ID_TYPE;
                                        2'd2:    tx_sh_d = ID_CAP;
                                        default: tx_sh_d = 8'h00;
                                    endcase
                                    if (byte_idx_q != 2'd3) byte_idx_d = byte_idx_q + 2'd1;
                                end
                                OP_RDSR: tx_sh_d = status_w;
                                OP_READ: mem_rd_d = 1'b1;
                                default: tx_sh_d = 8'h00;
                            endcase
                        end
                        S_DATA_WR: begin
                            mem_wr_d = 1'b1;
                            wdata_d  = rx_byte;
                            wrote_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            if (dclk_fall) begin
                if (state_q == S_DATA_RD) begin
                    miso_d  = tx_sh_q[7];
                    tx_sh_d = {tx_sh_q[6:0], 1'b0};
                end else begin
                    miso_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // cs idles high so releasing reset never looks like a transaction edge
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            cs_s3_q      <= 1'b1;
            dclk_s1_q    <= 1'b0;
            dclk_s2_q    <= 1'b0;
            dclk_s3_q    <= 1'b0;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            bits_q       <= 6'd0;
            byte_idx_q   <= 2'd0;
            cmd_q        <= 8'h00;
            rx_sh_q      <= 7'd0;
            tx_sh_q      <= 8'h00;
            miso_q       <= 1'b0;
            addr_q       <= 24'd0;
            wdata_q      <= 8'h00;
            wel_q        <= 1'b0;
            wip_q        <= 1'b0;
            prog_cnt_q   <= 16'd0;
            prog_act_q   <= 1'b0;
            erase_wait_q <= 1'b0;
            erase_type_q <= 1'b0;
            wrote_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            erase_req_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            cs_s1_q      <= i_spi_cs;
            cs_s2_q      <= cs_s1_q;
            cs_s3_q      <= cs_s2_q;
            dclk_s1_q    <= i_spi_dclk;
            dclk_s2_q    <= dclk_s1_q;
            dclk_s3_q    <= dclk_s2_q;
            mosi_s1_q    <= i_spi_mosi;
            mosi_s2_q    <= mosi_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bits_q       <= bits_d;
            byte_idx_q   <= byte_idx_d;
            cmd_q        <= cmd_d;
            rx_sh_q      <= rx_sh_d;
            tx_sh_q      <= tx_sh_d;
            miso_q       <= miso_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wel_q        <= wel_d;
            wip_q        <= wip_d;
            prog_cnt_q   <= prog_cnt_d;
            prog_act_q   <= prog_act_d;
            erase_wait_q <= erase_wait_d;
            erase_type_q <= erase_type_d;
            wrote_q      <= wrote_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            erase_req_q  <= erase_req_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    // raw cs gates miso so the line drops immediately, not after the synchronizer delay
    assign o_spi_miso   = miso_q & ~i_spi_cs;
    assign o_mem_addr   = addr_q;
    assign o_mem_rd     = mem_rd_q;
    assign o_mem_wr     = mem_wr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_erase_req  = erase_req_q;
    assign o_erase_type = erase_type_q;
    assign o_status     = status_w;

endmodule

// File: tb/tb_spi_flash_slave.sv
`timescale 1ns/1ps
module tb_spi_flash_slave;

    localparam int          H    = 8;        // clk cycles per dclk half period (16x oversampling)
    localparam logic [15:0] PROG = 16'd400;  // long enough to read RDSR while a program is busy

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        dclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        erase_req;
    logic        erase_type;
    logic        erase_done = 1'b0;
    logic [7:0]  status;

    always #5 clk = ~clk;

    spi_flash_slave #(.PROG_CYCLES(PROG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_spi_cs    (cs),
        .i_spi_dclk  (dclk),
        .i_spi_mosi  (mosi),
        .o_spi_miso  (miso),
        .o_mem_addr  (mem_addr),
        .o_mem_rd    (mem_rd),
        .i_mem_rdata (mem_rdata),
        .o_mem_wr    (mem_wr),
        .o_mem_wdata (mem_wdata),
        .o_erase_req (erase_req),
        .o_erase_type(erase_type),
        .i_erase_done(erase_done),
        .o_status    (status)
    );

    // store model: read data is the low address byte, one clk after the strobe
    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // strobe scoreboard: kind 0 = read, 1 = write, 2 = sector erase, 3 = bulk erase
    typedef struct {
        int          kind;
        logic [23:0] addr;
        logic [7:0]  dat;
    } stb_t;
    stb_t stq[$];
    stb_t st_act, st_exp;
    logic st_ok;

    always @(negedge clk) begin
        if (mem_rd || mem_wr || erase_req) begin
            st_act.kind = mem_rd ? 0 : (mem_wr ? 1 : (erase_type ? 3 : 2));
            st_act.addr = mem_addr;
            st_act.dat  = mem_wr ? mem_wdata : 8'h00;
            checks++;
            if (stq.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got kind=%0d addr=%h dat=%h want none",
                         st_act.kind, st_act.addr, st_act.dat);
            end else begin
                st_exp = stq.pop_front();
                st_ok = (st_act.kind == st_exp.kind) && (st_act.dat == st_exp.dat) &&
                        ((st_exp.kind == 3) || (st_act.addr == st_exp.addr));
                if (!st_ok) begin
                    errors++;
                    $display("FAIL strobe got kind=%0d addr=%h dat=%h want kind=%0d addr=%h dat=%h",
                             st_act.kind, st_act.addr, st_act.dat, st_exp.kind, st_exp.addr, st_exp.dat);
                end
            end
        end
    end

    // WIP pulse length monitor
    int wip_run = 0;
    int wip_last = 0;
    always @(negedge clk) begin
        if (status[0]) wip_run++;
        else if (wip_run != 0) begin
            wip_last = wip_run;
            wip_run  = 0;
        end
    end

    // vector table: bytes MSB-first in tx/exp, chk[7-k] enables the compare of response byte k
    typedef struct {
        int          nbits;
        logic [63:0] tx;
        logic [63:0] exp;
        logic [7:0]  chk;
        int          post;   // 0 none, 1 pulse erase_done, 2 wait for WIP to drop and check its length
    } vec_t;
    typedef struct {
        int          v;
        int          kind;
        logic [23:0] addr;
        logic [7:0]  dat;
    } sexp_t;
    vec_t  vt[$];
    string vname[$];
    sexp_t sx[$];
    logic [7:0] rxq[$];

    task automatic addv(input string nm, input int nb, input logic [63:0] tx,
                        input logic [63:0] exp, input logic [7:0] chk, input int post);
        vec_t v;
        v.nbits = nb; v.tx = tx; v.exp = exp; v.chk = chk; v.post = post;
        vt.push_back(v);
        vname.push_back(nm);
    endtask

    task automatic adds(input int kind, input logic [23:0] addr, input logic [7:0] dat);
        sexp_t s;
        s.v = vt.size() - 1; s.kind = kind; s.addr = addr; s.dat = dat;
        sx.push_back(s);
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [63:0] tx, input int nbits, output logic [63:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[63-i];
            clk_n(H);
            rx[63-i] = miso;   // master samples just before the rising edge
            dclk = 1'b1;
            clk_n(H);
            dclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [63:0] tx, input int nbits, output logic [63:0] rx);
        cs = 1'b0;
        clk_n(4);
        spi_bits(tx, nbits, rx);
        clk_n(H);
        cs   = 1'b1;
        mosi = 1'b0;
        clk_n(8);
    endtask

    task automatic pulse_done();
        clk_n(20);
        erase_done = 1'b1;
        clk_n(1);
        erase_done = 1'b0;
        clk_n(4);
    endtask

    task automatic wait_wip_len(input string nm);
        int n;
        n = 0;
        while (status[0] && n < 3000) begin
            clk_n(1);
            n++;
        end
        cmp({nm, "_wip_clear"}, {31'b0, status[0]}, 32'd0);
        clk_n(3);
        cmp({nm, "_wip_len"}, wip_last, {16'b0, PROG});
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rx;

        addv("RDID",    40, 64'h9F00000000000000, 64'h00EF401800000000, 8'b0111_1000, 0);
        addv("RDSR0",   16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("WREN",     8, 64'h0600000000000000, 64'h0, 8'b0, 0);
        addv("RDSRWEL", 24, 64'h0500000000000000, 64'h0002020000000000, 8'b0110_0000, 0);
        addv("WRDI",     8, 64'h0400000000000000, 64'h0, 8'b0, 0);
        addv("RDSRWRDI",16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("PPNOWEL", 40, 64'h02001000AA000000, 64'h0, 8'b0, 0);
        addv("RDSRNOPP",16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("READ",    56, 64'h03FFFFFE00000000, 64'h00000000FEFF0000, 8'b0000_1110, 0);
        adds(0, 24'hFFFFFE, 8'h00);
        adds(0, 24'hFFFFFF, 8'h00);
        adds(0, 24'h000000, 8'h00);
        adds(0, 24'h000001, 8'h00);
        addv("BADOP",   16, 64'hAB00000000000000, 64'h0000000000000000, 8'b1100_0000, 0);
        addv("WREN2",    8, 64'h0600000000000000, 64'h0, 8'b0, 0);
        addv("PP",      56, 64'h020001FE11223300, 64'h0, 8'b0, 1);
        adds(1, 24'h0001FE, 8'h11);
        adds(1, 24'h0001FF, 8'h22);
        adds(1, 24'h000100, 8'h33);
        addv("RDSRPP",  24, 64'h0500000000000000, 64'h0001010000000000, 8'b0110_0000, 2);
        addv("RDSRPP2", 16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("WREN3",    8, 64'h0600000000000000, 64'h0, 8'b0, 0);
        addv("SE",      32, 64'hD812345600000000, 64'h0, 8'b0, 0);
        adds(2, 24'h123456, 8'h00);
        addv("RDSRSE",  24, 64'h0500000000000000, 64'h0001010000000000, 8'b0110_0000, 0);
        addv("RDBUSY",  40, 64'h0300000000000000, 64'h0000000000000000, 8'b0100_1000, 1);
        addv("RDSRSE2", 16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("WREN4",    8, 64'h0600000000000000, 64'h0, 8'b0, 0);
        addv("SE20",    20, 64'hD812345000000000, 64'h0, 8'b0, 0);
        addv("RDSRSE20",16, 64'h0500000000000000, 64'h0002000000000000, 8'b0100_0000, 0);
        addv("BE",       8, 64'hC700000000000000, 64'h0, 8'b0, 0);
        adds(3, 24'h000000, 8'h00);
        addv("RDSRBE",  16, 64'h0500000000000000, 64'h0001000000000000, 8'b0100_0000, 1);
        addv("RDSRBE2", 16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("WREN9",    9, 64'h0600000000000000, 64'h0, 8'b0, 0);
        addv("RDSR9",   16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("BENOWEL",  8, 64'hC700000000000000, 64'h0, 8'b0, 0);
        addv("RDSRBENW",16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);
        addv("WREN5",    8, 64'h0600000000000000, 64'h0, 8'b0, 0);
        addv("PPPART",  44, 64'h0200001077A00000, 64'h0, 8'b0, 2);
        adds(1, 24'h000010, 8'h77);
        addv("RDSRPART",16, 64'h0500000000000000, 64'h0000000000000000, 8'b0100_0000, 0);

        // reset state
        clk_n(5);
        cmp("rst_ctl", {27'b0, miso, mem_rd, mem_wr, erase_req, erase_type}, 32'd0);
        cmp("rst_addr", {8'b0, mem_addr}, 32'd0);
        cmp("rst_wdata", {24'b0, mem_wdata}, 32'd0);
        cmp("rst_status", {24'b0, status}, 32'd0);
        rst_n = 1'b1;
        clk_n(5);

        for (int i = 0; i < vt.size(); i++) begin
            foreach (sx[j]) begin
                if (sx[j].v == i) stq.push_back('{kind: sx[j].kind, addr: sx[j].addr, dat: sx[j].dat});
            end
            for (int k = 0; k < 8; k++) begin
                if (vt[i].chk[7-k]) rxq.push_back(vt[i].exp[63-8*k -: 8]);
            end
            xfer(vt[i].tx, vt[i].nbits, rx);
            for (int k = 0; k < 8; k++) begin
                if (vt[i].chk[7-k]) cmp($sformatf("%s_byte%0d", vname[i], k), {24'b0, rx[63-8*k -: 8]},
                                        {24'b0, rxq.pop_front()});
            end
            cmp({vname[i], "_strobes_left"}, stq.size(), 32'd0);
            stq.delete();
            if (vt[i].post == 1) pulse_done();
            if (vt[i].post == 2) wait_wip_len(vname[i]);
        end

        // asynchronous reset in the middle of a page program
        xfer(64'h0600000000000000, 8, rx);
        stq.push_back('{kind: 1, addr: 24'h000000, dat: 8'hAB});
        cs = 1'b0;
        clk_n(4);
        spi_bits(64'h02000000ABA00000, 44, rx);
        clk_n(H);
        cmp("mid_status", {24'b0, status}, 32'h02);
        rst_n = 1'b0;
        clk_n(1);
        cmp("arst_status", {24'b0, status}, 32'd0);
        cmp("arst_ctl", {27'b0, miso, mem_rd, mem_wr, erase_req, erase_type}, 32'd0);
        cs = 1'b1;
        mosi = 1'b0;
        clk_n(4);
        rst_n = 1'b1;
        clk_n(10);
        cmp("arst_strobes_left", stq.size(), 32'd0);
        cmp("arst_no_wip", {24'b0, status}, 32'd0);
        xfer(64'h0500000000000000, 16, rx);
        cmp("arst_rdsr", {24'b0, rx[55:48]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
